sprite_motion: RTL and testbench
================================

Name: sprite_motion

Overview:
- Parametrised successor of the single-rectangle mover.
- Moves a framed rectangle across the visible area once per video frame and paints it into the RGB stream.
- Motion runs in one of three modes: stopped, manual (the user holds a direction input), or autonomous bounce/wrap at a selectable speed.
- Sits between the VGA timing generator (supplies x, y, disp_en, VGA_VS) and the video DAC; exports position and a bounce counter for the 7-segment path.

Parameters:
- H, 1280, visible width in pixels
- V, 1024, visible height in pixels
- W, 11, coordinate width in bits
- LARGHEZZA, 400, rectangle width
- ALTEZZA, 300, rectangle height
- SPESSORE, 20, frame thickness
- COL_FRAME, 24'hFF0000, RGB of the frame
- COL_IN, 24'h00FF00, RGB of the interior
- COL_BG, 24'h0000FF, RGB of the background

Ports:
- VGA_CLK, in, 1, pixel clock; the only clock
- reset, in, 1, asynchronous, active-high
- VGA_VS, in, 1, vertical sync level in the VGA_CLK domain
- disp_en, in, 1, visible-area qualifier
- x, in, W, current pixel column
- y, in, W, current pixel row
- mode, in, 2, 00 STOP, 01 MANUAL, 10 BOUNCE, 11 WRAP
- move_x, in, 1, MANUAL: step horizontally this frame
- move_y, in, 1, MANUAL: step vertically this frame
- dir_x, in, 1, MANUAL: 1 = right, 0 = left
- dir_y, in, 1, MANUAL: 1 = down, 0 = up
- speed, in, 4, pixels per frame; 0 is treated as 1
- r, g, b, out, 8 each, pixel colour
- posx, out, W, left edge of the rectangle
- posy, out, W, top edge of the rectangle
- bounce_cnt, out, 8, number of edge hits, saturating
- frame_tick, out, 1, one-cycle pulse on each update

Behaviour:
- Reset values:
  - posx = H/2-LARGHEZZA/2, posy = V/2-ALTEZZA/2
  - velocity direction registers vx_dir = 1, vy_dir = 1
  - bounce_cnt = 0; r, g, b = 0; frame_tick = 0
  - the VS edge-detect register resets to 1, so no spurious tick after reset
- Frame tick: VGA_VS is registered once; frame_tick = VS & ~VS_q (rising edge); exactly one pulse per frame.
- Position limits: XMAX = H-LARGHEZZA, YMAX = V-ALTEZZA. Position never leaves [0..XMAX] x [0..YMAX]. Step s = max(speed,1).
- Updates happen only on the cycle frame_tick is high. Axes are independent.
- STOP: position held; vx_dir and vy_dir held.
- MANUAL: an axis steps only if its move input is high, in the direction given by its dir input.
  - Past a limit, the axis wraps: right of XMAX goes to 0; left of 0 goes to XMAX; same rule for y.
  - vx_dir and vy_dir are loaded from dir_x and dir_y each tick, so switching to BOUNCE continues in the last manual direction.
- BOUNCE: each axis steps by s in the direction of its velocity register.
  - If the new value would reach or exceed a limit (>= max moving positive, <= 0 moving negative), the axis is clamped to the limit, its direction toggles, and bounce_cnt increments.
  - A simultaneous x and y hit (corner) increments bounce_cnt once and toggles both directions.
  - bounce_cnt saturates at 255.
- WRAP: same as BOUNCE with no clamp. Overshoot wraps to the opposite limit (position set exactly to 0 or the max, not modular), the direction is unchanged, and bounce_cnt increments.
- Arithmetic: the next-position computation uses W+1 bits signed so underflow is detectable; no truncation hazard.
- A mode change takes effect at the next frame_tick. An asserted reset at any point restores all reset values immediately (asynchronous).
- Pixel path: 1-cycle registered latency from x, y, disp_en to r, g, b.
  - The rectangle region is x in [posx, posx+LARGHEZZA), y in [posy, posy+ALTEZZA).
  - The frame is the part of the rectangle within SPESSORE of any edge; the interior is the rest.
  - Priority: frame > interior > background.
  - When disp_en = 0, r, g, b = 0.
  - Position used is the registered posx and posy. Position changes only at VS, so there is no tearing in the visible area.

Test Plan:
- Reset, then 3 VS pulses in STOP → posx = 440, posy = 362, bounce_cnt = 0; exactly 3 frame_tick pulses.
- MANUAL, move_x = 1, dir_x = 0, speed = 0, start posx = 0 → next tick posx = 880 (wrap to XMAX); posy unchanged; bounce_cnt = 0.
- BOUNCE, speed = 15, posx = 870, vx_dir = 1 → posx = 880, vx_dir = 0, bounce_cnt = 1; next tick posx = 865.
- BOUNCE corner: posx = 875, posy = 720, speed = 5, both directions positive → posx = 880, posy = 724, both directions flip, bounce_cnt += 1 only.
- Pixel check with posx = 100, posy = 100, disp_en = 1:
  - (105,105) → FF0000 one cycle later
  - (200,200) → 00FF00
  - (600,600) → 0000FF
  - disp_en = 0 → 000000
- Reset asserted mid-frame during BOUNCE with bounce_cnt = 255 → outputs return to reset values without a clock edge; bounce_cnt stays saturated at 255 under further hits before reset.

Source files
------------

// File: rtl/sprite_motion.sv
// sprite_motion: moves a framed rectangle once per frame (stop/manual/bounce/wrap) and paints it into the RGB stream.
module sprite_motion #(
    parameter int          H         = 1280,
    parameter int          V         = 1024,
    parameter int          W         = 11,
    parameter int          LARGHEZZA = 400,
    parameter int          ALTEZZA   = 300,
    parameter int          SPESSORE  = 20,
    parameter logic [23:0] COL_FRAME = 24'hFF0000,
    parameter logic [23:0] COL_IN    = 24'h00FF00,
    parameter logic [23:0] COL_BG    = 24'h0000FF
) (
    input  logic         VGA_CLK,
    input  logic         reset,
    input  logic         VGA_VS,
    input  logic         disp_en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [1:0]   mode,
    input  logic         move_x,
    input  logic         move_y,
    input  logic         dir_x,
    input  logic         dir_y,
    input  logic [3:0]   speed,
    output logic [7:0]   r,
    output logic [7:0]   g,
    output logic [7:0]   b,
    output logic [W-1:0] posx,
    output logic [W-1:0] posy,
    output logic [7:0]   bounce_cnt,
    output logic         frame_tick
);
    localparam logic signed [W:0] XL = (W+1)'(H - LARGHEZZA);
    localparam logic signed [W:0] YL = (W+1)'(V - ALTEZZA);
    localparam logic [W:0] LW = (W+1)'(LARGHEZZA);
    localparam logic [W:0] AH = (W+1)'(ALTEZZA);
    localparam logic [W:0] SP = (W+1)'(SPESSORE);

    logic         vs_q, vx_dir, vy_dir, in_rect, on_frame;
    logic [W:0]   st, xe, ye, x0, y0;
    logic [W+1:0] sx, sy;
    logic [23:0]  pix;

    // Returns {edge hit, next direction, next position} for one axis.
    function automatic logic [W+1:0] step_axis(input logic [W-1:0] p, input logic signed [W:0] lim,
                                               input logic vd, input logic mv, input logic md,
                                               input logic [1:0] m, input logic [W:0] s);
        logic d, ht;
        logic signed [W:0] n;
        logic [W-1:0] mn, q;
        d  = (m == 2'b01) ? md : vd;
        n  = d ? $signed({1'b0, p} + s) : $signed({1'b0, p} - s);
        mn = (n > lim) ? '0 : n[W] ? lim[W-1:0] : n[W-1:0];
        ht = m[1] & (d ? (n >= lim) : (n[W] | (n == '0)));
        q  = (m == 2'b00) ? p : (m == 2'b01) ? (mv ? mn : p) :
             !ht ? n[W-1:0] : (m[0] ^ d) ? lim[W-1:0] : '0;
        return {ht, (m == 2'b10 && ht) ? ~d : d, q};
    endfunction

    assign frame_tick = VGA_VS & ~vs_q;

    always_comb begin
        st       = (W+1)'((speed == 4'd0) ? 4'd1 : speed);
        sx       = step_axis(posx, XL, vx_dir, move_x, dir_x, mode, st);
        sy       = step_axis(posy, YL, vy_dir, move_y, dir_y, mode, st);
        xe       = {1'b0, x};
        ye       = {1'b0, y};
        x0       = {1'b0, posx};
        y0       = {1'b0, posy};
        in_rect  = xe >= x0 && xe < x0 + LW && ye >= y0 && ye < y0 + AH;
        on_frame = in_rect && (xe < x0 + SP || xe >= x0 + LW - SP || ye < y0 + SP || ye >= y0 + AH - SP);
        pix      = !disp_en ? 24'h0 : on_frame ? COL_FRAME : in_rect ? COL_IN : COL_BG;
    end

    // vs_q resets high so a VS level already high at release is not seen as an edge.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            vs_q       <= 1'b1;
            posx       <= W'(H/2 - LARGHEZZA/2);
            posy       <= W'(V/2 - ALTEZZA/2);
            vx_dir     <= 1'b1;
            vy_dir     <= 1'b1;
            bounce_cnt <= 8'd0;
            {r, g, b}  <= 24'h0;
        end else begin
            vs_q      <= VGA_VS;
            {r, g, b} <= pix;
            if (frame_tick) begin
                posx   <= sx[W-1:0];
                vx_dir <= sx[W];
                posy   <= sy[W-1:0];
                vy_dir <= sy[W];
                if ((sx[W+1] | sy[W+1]) && bounce_cnt != 8'hFF)
                    bounce_cnt <= bounce_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: table-driven frame vectors with a scoreboard queue, plus reset and pixel-path sequences.
module tb_sprite_motion;
    localparam int W = 11;

    logic         clk = 0, reset = 1, vs = 0, de = 0, mx = 0, my = 0, dx = 0, dy = 0;
    logic [W-1:0] x = 0, y = 0;
    logic [1:0]   mode = 0;
    logic [3:0]   speed = 0;
    logic [7:0]   r, g, b, bcnt;
    logic [W-1:0] posx, posy;
    logic         ft;

    always #5 clk = ~clk;

    sprite_motion dut (
        .VGA_CLK(clk), .reset(reset), .VGA_VS(vs), .disp_en(de), .x(x), .y(y),
        .mode(mode), .move_x(mx), .move_y(my), .dir_x(dx), .dir_y(dy), .speed(speed),
        .r(r), .g(g), .b(b), .posx(posx), .posy(posy), .bounce_cnt(bcnt), .frame_tick(ft)
    );

    typedef struct {
        logic [1:0] m;
        logic       mx, my, dx, dy;
        logic [3:0] s;
        int         ex, ey, eb;
    } mv_t;

    typedef struct {
        int          px, py;
        logic        de;
        logic [23:0] rgb;
    } px_t;

    mv_t         tbl[$];
    mv_t         exq[$];
    px_t         ptbl[$];
    logic [23:0] pq[$];
    int compared = 0, mismatched = 0, ticks = 0, t0 = 0;

    always @(posedge clk) if (ft) ticks++;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic void add(input int m, input int mx_, input int my_, input int dx_, input int dy_,
                                input int s, input int ex, input int ey, input int eb);
        mv_t v;
        v.m = 2'(m); v.mx = mx_[0]; v.my = my_[0]; v.dx = dx_[0]; v.dy = dy_[0];
        v.s = 4'(s); v.ex = ex; v.ey = ey; v.eb = eb;
        tbl.push_back(v);
    endfunction

    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction

    task automatic run(input mv_t v);
        mv_t e;
        @(negedge clk);
        mode = v.m; mx = v.mx; my = v.my; dx = v.dx; dy = v.dy; speed = v.s;
        vs = 1;
        exq.push_back(v);
        #1;
        chk("frame_tick_on_vs_rise", int'(ft), 1);
        @(negedge clk);
        e = exq.pop_front();
        chk("posx", int'(posx), e.ex);
        chk("posy", int'(posy), e.ey);
        chk("bounce_cnt", int'(bcnt), e.eb);
        vs = 0;
        @(negedge clk);
    endtask

    task automatic apply_all();
        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
            if (i == 2) chk("stop_tick_count", ticks - t0, 3);
        end
        tbl.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // STOP frames, then manual walk to the left edge and a wrap to XMAX
        repeat (3) add(0, 0, 0, 0, 0, 0, 440, 362, 0);
        for (int i = 1; i <= 29; i++) add(1, 1, 0, 0, 1, 15, 440 - 15 * i, 362, 0);
        add(1, 1, 0, 0, 1, 5, 0, 362, 0);
        add(1, 1, 0, 0, 1, 0, 880, 362, 0);
        add(1, 1, 0, 0, 1, 10, 870, 362, 0);
        add(1, 0, 0, 1, 1, 10, 870, 362, 0);
        add(2, 0, 0, 0, 0, 15, 880, 377, 1);
        add(2, 0, 0, 0, 0, 15, 865, 392, 1);
        // corner hit at (880,724)
        add(1, 1, 0, 1, 1, 10, 875, 392, 1);
        for (int i = 1; i <= 21; i++) add(1, 0, 1, 1, 1, 15, 875, 392 + 15 * i, 1);
        add(1, 0, 1, 1, 1, 13, 875, 720, 1);
        add(2, 0, 0, 0, 0, 5, 880, 724, 2);
        add(2, 0, 0, 0, 0, 5, 875, 719, 2);
        // WRAP overshoot on the right edge keeps direction
        add(1, 0, 0, 1, 0, 15, 875, 719, 2);
        add(3, 0, 0, 0, 0, 15, 0, 704, 3);
        add(3, 0, 0, 0, 0, 15, 15, 689, 3);
        // repeated left-edge hits drive the counter into saturation
        add(1, 0, 0, 0, 0, 15, 15, 689, 3);
        add(2, 0, 0, 0, 0, 15, 0, 674, 4);
        for (int i = 1; i <= 260; i++) begin
            add(1, 0, 0, 0, 0, 1, 0, 674 - (i - 1), sat(4 + i - 1));
            add(2, 0, 0, 0, 0, 1, 0, 674 - i, sat(4 + i));
        end

        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        chk("reset_posx", int'(posx), 440);
        chk("reset_posy", int'(posy), 362);
        chk("reset_bcnt", int'(bcnt), 0);
        chk("reset_rgb", int'({r, g, b}), 0);
        chk("reset_tick", int'(ft), 0);
        t0 = ticks;
        apply_all();

        // asynchronous reset in the middle of a clock period, still in BOUNCE
        @(negedge clk);
        de = 1; x = 1200; y = 1000;
        @(negedge clk);
        chk("pre_reset_rgb", int'({r, g, b}), 24'h0000FF);
        #2;
        reset = 1; vs = 1;
        #1;
        chk("async_reset_posx", int'(posx), 440);
        chk("async_reset_posy", int'(posy), 362);
        chk("async_reset_bcnt", int'(bcnt), 0);
        chk("async_reset_rgb", int'({r, g, b}), 0);
        chk("async_reset_tick", int'(ft), 0);
        @(negedge clk);
        reset = 0;
        t0 = ticks;
        repeat (3) @(negedge clk);
        chk("no_spurious_tick", ticks - t0, 0);
        vs = 0;
        de = 0;
        @(negedge clk);

        // walk to (100,100) for the pixel checks
        for (int i = 1; i <= 22; i++) add(1, 1, 0, 0, 0, 15, 440 - 15 * i, 362, 0);
        add(1, 1, 0, 0, 0, 10, 100, 362, 0);
        for (int i = 1; i <= 17; i++) add(1, 0, 1, 0, 0, 15, 100, 362 - 15 * i, 0);
        add(1, 0, 1, 0, 0, 7, 100, 100, 0);
        apply_all();

        ptbl = '{
            '{105, 105, 1'b1, 24'hFF0000}, '{200, 200, 1'b1, 24'h00FF00},
            '{600, 600, 1'b1, 24'h0000FF}, '{200, 200, 1'b0, 24'h000000},
            '{119, 200, 1'b1, 24'hFF0000}, '{120, 200, 1'b1, 24'h00FF00},
            '{479, 200, 1'b1, 24'h00FF00}, '{480, 200, 1'b1, 24'hFF0000},
            '{499, 200, 1'b1, 24'hFF0000}, '{500, 200, 1'b1, 24'h0000FF},
            '{99,  200, 1'b1, 24'h0000FF}, '{200, 379, 1'b1, 24'h00FF00},
            '{200, 380, 1'b1, 24'hFF0000}, '{200, 399, 1'b1, 24'hFF0000},
            '{200, 400, 1'b1, 24'h0000FF}, '{200, 99,  1'b1, 24'h0000FF}
        };
        for (int i = 0; i < ptbl.size(); i++) begin
            @(negedge clk);
            if (pq.size() > 0) chk("pixel_rgb", int'({r, g, b}), int'(pq.pop_front()));
            x = W'(ptbl[i].px); y = W'(ptbl[i].py); de = ptbl[i].de;
            pq.push_back(ptbl[i].rgb);
        end
        @(negedge clk);
        chk("pixel_rgb", int'({r, g, b}), int'(pq.pop_front()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
